// File: rtl/microc_ctrl.sv
// microc_ctrl: control unit for the microc datapath.
// Decodes opcode and registered z into datapath controls with skip/stall/halt.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode[OP_W+2:0] : {class[1:0], reserved, f[OP_W-1:0]}
//   z                : registered zero flag from the datapath
//   mem_rdy          : instruction memory output valid
//   s_inc, s_inm, s_skip, pc_en, we3, wez, op[OP_W-1:0] : datapath controls
//   halted           : block is in HALT
//   retired, skips_taken [CNT_W-1:0] : saturating statistics counters
//
// Build option: define MICROC_CTRL_STATS_EN to implement the counters;
// otherwise both counter outputs are tied to 0 and no counter flops exist.

module microc_ctrl #(
    parameter int              OP_W   = 3,
    parameter logic [OP_W-1:0] SUB_OP = OP_W'(3),
    parameter int              CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W+2:0]   opcode,
    input  logic              z,
    input  logic              mem_rdy,
    output logic              s_inc,
    output logic              s_inm,
    output logic              s_skip,
    output logic              pc_en,
    output logic              we3,
    output logic              wez,
    output logic [OP_W-1:0]   op,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  skips_taken
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t state, state_nx;

    // 0: skipeq (skip when z), 1: skipne (skip when !z).
    // Latched at the compare cycle since the opcode may move on.
    logic pol, pol_nx;

    logic [1:0]      cls;
    logic [OP_W-1:0] f;
    logic            unused_rsvd;

    assign cls         = opcode[OP_W+2:OP_W+1];
    assign f           = opcode[OP_W-1:0];
    assign unused_rsvd = opcode[OP_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pol   <= 1'b0;
        end else begin
            state <= state_nx;
            pol   <= pol_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pol_nx   = pol;
        s_inc    = 1'b0;
        s_inm    = 1'b0;
        s_skip   = 1'b0;
        pc_en    = 1'b0;
        we3      = 1'b0;
        wez      = 1'b0;
        op       = '0;
        halted   = 1'b0;

        unique case (state)
            BOOT: state_nx = RUN;

            RUN: begin
                // Without mem_rdy everything stays quiet and the state holds.
                if (mem_rdy) begin
                    unique case (cls)
                        2'b00: begin
                            op    = f;
                            we3   = 1'b1;
                            wez   = 1'b1;
                            s_inc = 1'b1;
                            pc_en = 1'b1;
                        end
                        2'b01: begin
                            s_inm = 1'b1;
                            we3   = 1'b1;
                            s_inc = 1'b1;
                            pc_en = 1'b1;
                        end
                        2'b10: begin
                            pc_en = 1'b1;
                            if (f == OP_W'(0))
                                s_inc = 1'b0;
                            else if (f == OP_W'(1))
                                s_inc = !z;
                            else if (f == OP_W'(2))
                                s_inc = z;
                            else
                                s_inc = 1'b1;
                        end
                        default: begin
                            if (f == OP_W'(0) || f == OP_W'(1)) begin
                                // Compare cycle: PC holds, z gets result.
                                op       = SUB_OP;
                                wez      = 1'b1;
                                pol_nx   = f[0];
                                state_nx = SKIP;
                            end else if (f == OP_W'(7)) begin
                                state_nx = HALT;
                            end else begin
                                s_inc = 1'b1;
                                pc_en = 1'b1;
                            end
                        end
                    endcase
                end
            end

            SKIP: begin
                // z now holds the registered compare result.
                s_inc    = 1'b1;
                pc_en    = 1'b1;
                s_skip   = z ^ pol;
                state_nx = RUN;
            end

            default: halted = 1'b1;
        endcase
    end

`ifdef MICROC_CTRL_STATS_EN
    logic [CNT_W-1:0] ret_q;
    logic [CNT_W-1:0] skp_q;
    logic             skip_hit;

    assign skip_hit = (state == SKIP) && s_skip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_q <= '0;
            skp_q <= '0;
        end else begin
            if (pc_en && (ret_q != '1))
                ret_q <= ret_q + 1'b1;
            if (skip_hit && (skp_q != '1))
                skp_q <= skp_q + 1'b1;
        end
    end

    assign retired     = ret_q;
    assign skips_taken = skp_q;
`else
    assign retired     = '0;
    assign skips_taken = '0;
`endif

endmodule

// File: tb/tb_microc_ctrl.sv
// tb_microc_ctrl: directed, table-driven bench for microc_ctrl.
// Counters are checked against 0 when MICROC_CTRL_STATS_EN is undefined.

module tb_microc_ctrl;

`ifdef MICROC_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic       z = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       s_inc, s_inm, s_skip, pc_en, we3, wez, halted;
    logic [2:0] op;
    logic [3:0] retired, skips_taken;
    logic [9:0] act;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    microc_ctrl #(
        .OP_W   (3),
        .SUB_OP (3'b011),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .z           (z),
        .mem_rdy     (mem_rdy),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .s_skip      (s_skip),
        .pc_en       (pc_en),
        .we3         (we3),
        .wez         (wez),
        .op          (op),
        .halted      (halted),
        .retired     (retired),
        .skips_taken (skips_taken)
    );

    assign act = {s_inc, s_inm, s_skip, pc_en, we3, wez, op, halted};

    // {s_inc, s_inm, s_skip, pc_en, we3, wez, op, halted}
    function automatic logic [9:0] o(input bit si, input bit sm,
                                     input bit sk, input bit pe,
                                     input bit we, input bit wz,
                                     input int opv, input bit h);
        return {si, sm, sk, pe, we, wz, 3'(opv), h};
    endfunction

    typedef struct {
        string      nm;
        logic [5:0] oc;
        logic       zz;
        logic       rdy;
        logic [9:0] ex;
    } vec_t;

    vec_t tv[14];

    task automatic chk_now(input string nm, input logic [9:0] ex);
        n_chk++;
        if (act === ex) n_pass++;
        else $display("FAIL %s: outputs got %b want %b", nm, act, ex);
    endtask

    task automatic chk_cnt(input string nm, input logic [3:0] got,
                           input logic [3:0] ex);
        n_chk++;
        if (got === ex) n_pass++;
        else $display("FAIL %s: counter got %0d want %0d", nm, got, ex);
    endtask

    task automatic drive(input logic [5:0] oc, input logic zz,
                         input logic rdy);
        opcode  = oc;
        z       = zz;
        mem_rdy = rdy;
    endtask

    // Check mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string nm, input logic [9:0] ex);
        @(negedge clk);
        chk_now(nm, ex);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_now("reset_out", '0);
        chk_cnt("reset_ret", retired, 4'd0);
        chk_cnt("reset_skp", skips_taken, 4'd0);
        reset = 1'b1;
        drive(6'b000010, 1'b0, 1'b1);
        cyc("boot", '0);
    endtask

    initial begin
        tv[0]  = '{"alu_add",   6'b000010, 1'b0, 1'b1, o(1,0,0,1,1,1,2,0)};
        tv[1]  = '{"alu_rsvd",  6'b001101, 1'b1, 1'b1, o(1,0,0,1,1,1,5,0)};
        tv[2]  = '{"li_0",      6'b010000, 1'b0, 1'b1, o(1,1,0,1,1,0,0,0)};
        tv[3]  = '{"li_f",      6'b011111, 1'b1, 1'b1, o(1,1,0,1,1,0,0,0)};
        tv[4]  = '{"jmp",       6'b100000, 1'b0, 1'b1, o(0,0,0,1,0,0,0,0)};
        tv[5]  = '{"jmp_rsvd",  6'b101000, 1'b1, 1'b1, o(0,0,0,1,0,0,0,0)};
        tv[6]  = '{"jz_z1",     6'b100001, 1'b1, 1'b1, o(0,0,0,1,0,0,0,0)};
        tv[7]  = '{"jz_z0",     6'b100001, 1'b0, 1'b1, o(1,0,0,1,0,0,0,0)};
        tv[8]  = '{"jnz_z1",    6'b100010, 1'b1, 1'b1, o(1,0,0,1,0,0,0,0)};
        tv[9]  = '{"jnz_z0",    6'b100010, 1'b0, 1'b1, o(0,0,0,1,0,0,0,0)};
        tv[10] = '{"jnop",      6'b100101, 1'b0, 1'b1, o(1,0,0,1,0,0,0,0)};
        tv[11] = '{"snop",      6'b110011, 1'b1, 1'b1, o(1,0,0,1,0,0,0,0)};
        tv[12] = '{"stall_li",  6'b010101, 1'b0, 1'b0, '0};
        tv[13] = '{"stall_alu", 6'b000111, 1'b1, 1'b0, '0};

        // Single-cycle decode table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].oc, tv[i].zz, tv[i].rdy);
            cyc(tv[i].nm, tv[i].ex);
        end
        chk_cnt("table_ret", retired, STATS ? 4'd12 : 4'd0);

        // li stall for 3 cycles, then ready.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(6'b010011, 1'b0, 1'b0);
            cyc("li_stall", '0);
        end
        chk_cnt("li_stall_ret", retired, 4'd0);
        drive(6'b010011, 1'b0, 1'b1);
        cyc("li_ready", o(1,1,0,1,1,0,0,0));
        chk_cnt("li_ready_ret", retired, STATS ? 4'd1 : 4'd0);

        // Skip sequences.
        do_reset();
        drive(6'b110000, 1'b0, 1'b1);
        cyc("skeq_cmp", o(0,0,0,0,0,1,3,0));
        drive(6'b000111, 1'b1, 1'b1);
        cyc("skeq_z1", o(1,0,1,1,0,0,0,0));
        chk_cnt("skeq_z1_skp", skips_taken, STATS ? 4'd1 : 4'd0);
        chk_cnt("skeq_z1_ret", retired, STATS ? 4'd1 : 4'd0);
        drive(6'b110000, 1'b1, 1'b0);
        cyc("skcmp_stall", '0);
        drive(6'b110000, 1'b1, 1'b1);
        cyc("skeq_cmp2", o(0,0,0,0,0,1,3,0));
        drive(6'b110000, 1'b0, 1'b0);
        cyc("skeq_z0", o(1,0,0,1,0,0,0,0));
        chk_cnt("skeq_z0_skp", skips_taken, STATS ? 4'd1 : 4'd0);
        drive(6'b110001, 1'b1, 1'b1);
        cyc("skne_cmp", o(0,0,0,0,0,1,3,0));
        drive(6'b000000, 1'b0, 1'b1);
        cyc("skne_z0", o(1,0,1,1,0,0,0,0));
        drive(6'b110001, 1'b0, 1'b1);
        cyc("skne_cmp2", o(0,0,0,0,0,1,3,0));
        drive(6'b110001, 1'b1, 1'b1);
        cyc("skne_z1", o(1,0,0,1,0,0,0,0));
        chk_cnt("skne_skp", skips_taken, STATS ? 4'd2 : 4'd0);
        chk_cnt("skne_ret", retired, STATS ? 4'd4 : 4'd0);

        // Reset during SKIP abandons it.
        drive(6'b110000, 1'b1, 1'b1);
        cyc("midskip_cmp", o(0,0,0,0,0,1,3,0));
        reset = 1'b0;
        #1;
        chk_now("midskip_rst", '0);
        chk_cnt("midskip_ret", retired, 4'd0);

        // Halt.
        do_reset();
        drive(6'b110111, 1'b0, 1'b1);
        cyc("halt_dec", '0);
        drive(6'b000010, 1'b0, 1'b1);
        cyc("halt_alu", o(0,0,0,0,0,0,0,1));
        drive(6'b010000, 1'b1, 1'b1);
        cyc("halt_li", o(0,0,0,0,0,0,0,1));
        drive(6'b110000, 1'b1, 1'b1);
        cyc("halt_skip", o(0,0,0,0,0,0,0,1));
        reset = 1'b0;
        #1;
        chk_now("halt_rst", '0);
        chk_cnt("halt_rst_ret", retired, 4'd0);

        // Saturation with CNT_W=4.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(6'b010001, 1'b0, 1'b1);
            cyc("sat_li", o(1,1,0,1,1,0,0,0));
        end
        chk_cnt("sat_ret", retired, STATS ? 4'hF : 4'd0);
        chk_cnt("sat_skp", skips_taken, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/microc_ctrl.md
# microc_ctrl

Parametrised control unit for the `microc` datapath. It decodes the instruction opcode and the registered zero flag into the datapath control signals `s_inc`, `s_inm`, `s_skip`, `we3`, `wez` and `op`, replacing hand-driven control from the bench. It adds four behaviours:
- a two-cycle skip sequence that compares, then decides;
- an instruction-memory ready stall;
- a halt state;
- optional retired-instruction statistics.

## Interface
Parameters:
- `OP_W`, 3: ALU operation width. The opcode width is `CODE_W = OP_W + 3`.
- `SUB_OP`, 3'b011: ALU code driven on `op` for the compare cycle of skip instructions.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  CODE_W  current instruction opcode.
- `z`  in  1  registered zero flag from the datapath.
- `mem_rdy`  in  1  instruction memory output is valid this cycle.
- `s_inc`  out  1  1 selects PC increment; 0 selects jump target.
- `s_inm`  out  1  1 selects the immediate for write-back.
- `s_skip`  out  1  1 makes the increment +2 instead of +1.
- `pc_en`  out  1  PC register load enable.
- `we3`  out  1  register bank write enable.
- `wez`  out  1  zero-flag write enable.
- `op`  out  OP_W  ALU operation.
- `halted`  out  1  block is in HALT.
- `retired`  out  CNT_W  completed instruction count.
- `skips_taken`  out  CNT_W  count of skips taken.

## Operation
Opcode fields:
- `class = opcode[CODE_W-1:CODE_W-2]`
- `f = opcode[OP_W-1:0]`
- bit `OP_W` is reserved and ignored.

Decoding in RUN state with `mem_rdy=1`. Any output not listed is 0.
- class 00, ALU: `op=f`, `we3=1`, `wez=1`, `s_inc=1`, `pc_en=1`.
- class 01, li: `s_inm=1`, `we3=1`, `s_inc=1`, `pc_en=1`.
- class 10, jumps, `pc_en=1`:
  - f=0 jmp: `s_inc=0`.
  - f=1 jz: `s_inc=!z`.
  - f=2 jnz: `s_inc=z`.
  - Other f values: nop, `s_inc=1`.
- class 11, special:
  - f=0 skipeq, f=1 skipne: compare cycle with `op=SUB_OP`, `wez=1`, `we3=0`, `pc_en=0`. Next state is SKIP.
  - f=7 halt: next state is HALT, `pc_en=0`.
  - Other f values: nop, `s_inc=1`, `pc_en=1`.

FSM states are BOOT, RUN, SKIP and HALT.
- BOOT: all outputs 0. Goes to RUN unconditionally after one cycle.
- RUN: decode as above.
  - With `mem_rdy=0`, all enables (`pc_en`, `we3`, `wez`) are 0 and the state holds.
- SKIP: `s_inc=1`, `pc_en=1`.
  - `s_skip` is `z` for skipeq and `!z` for skipne.
  - Skip polarity is latched in the compare cycle, because the opcode may change.
  - `mem_rdy` is ignored.
  - Returns to RUN.
- HALT: all enables 0 and `halted=1`. Only reset leaves HALT.

Controls are combinational from the state, `opcode`, `z` and the latched skip polarity. Only the state, the polarity bit and the counters are registered.

Counters:
- `retired` increments on every cycle with `pc_en=1`.
- `skips_taken` increments on a SKIP cycle with `s_skip=1`.
- Both saturate at all-ones and do not wrap.

## Timing
- Reset:
  - State is BOOT, all outputs 0, counters 0, `halted=0`.
  - Asserting reset mid-skip abandons the skip; no PC update occurs.
- Latency:
  - First instruction is decoded in the 2nd rising edge after reset release.
  - ALU, li, jump and nop instructions take 1 cycle.
  - Skip instructions take 2 cycles: the compare cycle, then the decision cycle.
  - Halt takes effect the cycle after decode.
- `z` sampling:
  - In the SKIP cycle, `z` must reflect the compare result written in the previous cycle, because the datapath registers z.
  - Conditional jumps use `z` as presented in the same cycle.
- `mem_rdy` low during the compare cycle: the compare is not issued (`wez=0`) and the state stays RUN.
- Reserved opcodes never write the register bank or the zero flag.

## Configuration
- `MICROC_CTRL_STATS_EN` defined: `retired` and `skips_taken` counters are implemented as above.
- Undefined: both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset then `opcode=6'b000010`, `mem_rdy=1`:
  - BOOT cycle with all outputs 0.
  - Next cycle: `op=3'b010`, `we3=1`, `wez=1`, `pc_en=1`, `s_inc=1`.
- `opcode=6'b110000` (skipeq), `z=1` in the second cycle:
  - Cycle 1: `op=3'b011`, `wez=1`, `pc_en=0`.
  - Cycle 2: `s_skip=1`, `pc_en=1`.
  - `skips_taken=1`.
  - Repeat with `z=0`: cycle 2 gives `s_skip=0`.
- jz `6'b100001`:
  - With `z=1`: `s_inc=0`.
  - With `z=0`: `s_inc=1`.
  - `pc_en=1` in both cases.
- li `6'b01xxxx` with `mem_rdy=0` for 3 cycles, then 1:
  - During the stall: `pc_en=we3=0`.
  - On ready: `s_inm=1`, `we3=1`.
  - `retired` advances by exactly 1.
- halt `6'b110111`:
  - `halted=1` from the next cycle.
  - Any later opcode gives all enables 0.
  - Async reset low returns to BOOT with counters 0.
- With `MICROC_CTRL_STATS_EN` and `CNT_W=4`:
  - 20 li instructions give `retired=4'hF`, saturated.
  - Without the macro, both counters stay 0.
